// File: rtl/alu_seq_unit.sv
// alu_seq_unit: WIDTH-bit EX-stage ALU. Latency is 1 cycle, or WIDTH cycles for MULTU. Outputs hold while OutValid && !OutReady.
// ALU_SHIFT_EN adds SLL/SRL on Sel 100/101. Without it those codes take the Illegal path.
module alu_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [2:0]       Sel,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] DataOut,
  output logic [WIDTH-1:0] DataOutHi,
  output logic             Zero,
  output logic             Cout,
  output logic             Overflow,
  output logic             Illegal
);

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_MULTU = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b110;
  localparam logic [2:0] OP_SLT   = 3'b111;
`ifdef ALU_SHIFT_EN
  localparam logic [2:0] OP_SLL   = 3'b100;
  localparam logic [2:0] OP_SRL   = 3'b101;
`endif

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             cout;
    logic             overflow;
    logic             illegal;
  } res_t;

  state_t             state, stateNxt;
  res_t               res, resNxt, aluRes;
  logic               outValid, outValidNxt;
  logic [CNT_W-1:0]   cnt, cntNxt;
  logic [WIDTH-1:0]   mulA, mulANxt;
  logic [WIDTH-1:0]   mulB, mulBNxt;
  logic [2*WIDTH-1:0] acc, accNxt, accStep;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     addSum, subSum;
  logic               accept;

  assign InReady = (state == IDLE) && (!outValid || OutReady);
  assign accept  = InValid && InReady;

  assign addSum = {1'b0, DataA} + {1'b0, DataB};
  assign subSum = {1'b0, DataA} + {1'b0, ~DataB} + {{WIDTH{1'b0}}, 1'b1};

`ifdef ALU_SHIFT_EN
  logic [CNT_W-2:0] shAmt;
  logic             shTooBig;
  assign shAmt    = DataB[CNT_W-2:0];
  assign shTooBig = ({1'b0, shAmt} >= WIDTH_C);
`endif

  // Single-cycle datapath; MULTU is sequenced by the FSM below.
  always_comb begin
    aluRes = '0;
    case (Sel)
      OP_AND: aluRes.lo = DataA & DataB;
      OP_OR:  aluRes.lo = DataA | DataB;
      OP_ADD: begin
        aluRes.lo       = addSum[WIDTH-1:0];
        aluRes.cout     = addSum[WIDTH];
        aluRes.overflow = (DataA[WIDTH-1] == DataB[WIDTH-1]) &&
                          (addSum[WIDTH-1] != DataA[WIDTH-1]);
      end
      OP_SUB: begin
        aluRes.lo       = subSum[WIDTH-1:0];
        aluRes.cout     = subSum[WIDTH];
        aluRes.overflow = (DataA[WIDTH-1] != DataB[WIDTH-1]) &&
                          (subSum[WIDTH-1] != DataA[WIDTH-1]);
      end
      OP_SLT:   aluRes.lo = {{(WIDTH-1){1'b0}}, ($signed(DataA) < $signed(DataB))};
      OP_MULTU: aluRes.illegal = 1'b0;
`ifdef ALU_SHIFT_EN
      OP_SLL: aluRes.lo = shTooBig ? '0 : (DataA << shAmt);
      OP_SRL: aluRes.lo = shTooBig ? '0 : (DataA >> shAmt);
`endif
      default: aluRes.illegal = 1'b1;
    endcase
    aluRes.zero = (aluRes.lo == '0);
  end

  // One shift-add step: conditional add into the upper half, then {carry, acc} >> 1.
  assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mulB[0] ? {1'b0, mulA} : '0);
  assign accStep = (2*WIDTH)'({mulSum, acc[WIDTH-1:0]} >> 1);

  always_comb begin
    stateNxt    = state;
    resNxt      = res;
    outValidNxt = outValid;
    cntNxt      = cnt;
    mulANxt     = mulA;
    mulBNxt     = mulB;
    accNxt      = acc;

    if (outValid && OutReady) begin
      outValidNxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (accept) begin
          if (Sel == OP_MULTU) begin
            mulANxt  = DataA;
            mulBNxt  = DataB;
            accNxt   = '0;
            cntNxt   = WIDTH_C;
            stateNxt = MUL;
          end else begin
            resNxt      = aluRes;
            outValidNxt = 1'b1;
          end
        end
      end
      MUL: begin
        accNxt  = accStep;
        mulBNxt = mulB >> 1;
        cntNxt  = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          resNxt.lo       = accStep[WIDTH-1:0];
          resNxt.hi       = accStep[2*WIDTH-1:WIDTH];
          resNxt.zero     = (accStep == '0);
          resNxt.cout     = 1'b0;
          resNxt.overflow = 1'b0;
          resNxt.illegal  = 1'b0;
          outValidNxt     = 1'b1;
          stateNxt        = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      res      <= '0;
      outValid <= 1'b0;
      cnt      <= '0;
      mulA     <= '0;
      mulB     <= '0;
      acc      <= '0;
    end else begin
      state    <= stateNxt;
      res      <= resNxt;
      outValid <= outValidNxt;
      cnt      <= cntNxt;
      mulA     <= mulANxt;
      mulB     <= mulBNxt;
      acc      <= accNxt;
    end
  end

  assign OutValid  = outValid;
  assign DataOut   = res.lo;
  assign DataOutHi = res.hi;
  assign Zero      = res.zero;
  assign Cout      = res.cout;
  assign Overflow  = res.overflow;
  assign Illegal   = res.illegal;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit at WIDTH=8; expectations are hand-computed per vector.
module tb_alu_seq_unit;
  localparam int WIDTH = 8;
  localparam logic [2:0] S_AND = 3'b000, S_OR = 3'b001, S_ADD = 3'b010, S_MUL = 3'b011;
  localparam logic [2:0] S_SLL = 3'b100, S_SRL = 3'b101, S_SUB = 3'b110, S_SLT = 3'b111;

  logic             Clk, Reset_n, InValid, InReady, OutValid, OutReady;
  logic             Zero, Cout, Overflow, Illegal;
  logic [2:0]       Sel;
  logic [WIDTH-1:0] DataA, DataB, DataOut, DataOutHi;
  int checks = 0;
  int errors = 0;

  alu_seq_unit #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady), .Sel(Sel),
    .DataA(DataA), .DataB(DataB), .OutValid(OutValid), .OutReady(OutReady),
    .DataOut(DataOut), .DataOutHi(DataOutHi), .Zero(Zero), .Cout(Cout),
    .Overflow(Overflow), .Illegal(Illegal)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic drive(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b, input logic v);
    @(negedge Clk);
    Sel = s; DataA = a; DataB = b; InValid = v;
  endtask

  task automatic test_reset();
    Reset_n = 1'b1; InValid = 1'b0; OutReady = 1'b0; Sel = '0; DataA = '0; DataB = '0;
    #2 Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL rst_outvalid got %b exp 0", OutValid); end
    checks++; if (DataOut !== 8'h00) begin errors++; $display("FAIL rst_dataout got %h exp 00", DataOut); end
    checks++; if (DataOutHi !== 8'h00) begin errors++; $display("FAIL rst_dataouthi got %h exp 00", DataOutHi); end
    checks++; if ({Zero, Cout, Overflow, Illegal} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b exp 0000", {Zero, Cout, Overflow, Illegal}); end
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL rst_inready got %b exp 1", InReady); end
  endtask

  task automatic test_add();
    OutReady = 1'b0;
    drive(S_ADD, 8'h7F, 8'h01, 1'b1);
    #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL add_pre_valid got %b exp 0", OutValid); end
    @(posedge Clk); #1;
    checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", OutValid); end
    checks++; if (DataOut !== 8'h80) begin errors++; $display("FAIL add_data got %h exp 80", DataOut); end
    checks++; if ({Zero, Cout, Overflow, Illegal} !== 4'b0010) begin errors++; $display("FAIL add_flags zcoi got %b exp 0010", {Zero, Cout, Overflow, Illegal}); end
    checks++; if (DataOutHi !== 8'h00) begin errors++; $display("FAIL add_hi got %h exp 00", DataOutHi); end
    @(negedge Clk);
    InValid = 1'b0; OutReady = 1'b1;
    @(posedge Clk); #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL add_drain got %b exp 0", OutValid); end
    checks++; if (DataOut !== 8'h80) begin errors++; $display("FAIL add_held got %h exp 80", DataOut); end
  endtask

  task automatic test_sub_slt();
    OutReady = 1'b1;
    drive(S_SUB, 8'h05, 8'h05, 1'b1);
    @(posedge Clk); #1;
    checks++; if (DataOut !== 8'h00) begin errors++; $display("FAIL sub_data got %h exp 00", DataOut); end
    checks++; if ({Zero, Cout, Overflow, Illegal} !== 4'b1100) begin errors++; $display("FAIL sub_flags zcoi got %b exp 1100", {Zero, Cout, Overflow, Illegal}); end
    drive(S_SLT, 8'hFF, 8'h01, 1'b1);
    @(posedge Clk); #1;
    checks++; if (DataOut !== 8'h01) begin errors++; $display("FAIL slt_neg_data got %h exp 01", DataOut); end
    checks++; if ({Zero, Cout, Overflow, Illegal, OutValid} !== 5'b00001) begin errors++; $display("FAIL slt_neg_flags zcoiv got %b exp 00001", {Zero, Cout, Overflow, Illegal, OutValid}); end
    drive(S_SLT, 8'h01, 8'hFF, 1'b1);
    @(posedge Clk); #1;
    checks++; if ({DataOut, Zero} !== {8'h00, 1'b1}) begin errors++; $display("FAIL slt_pos got data %h zero %b exp 00 1", DataOut, Zero); end
    drive(S_AND, 8'h00, 8'h00, 1'b0);
    @(posedge Clk); #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL slt_drain got %b exp 0", OutValid); end
  endtask

  task automatic test_backpressure();
    OutReady = 1'b0;
    drive(S_AND, 8'hF0, 8'h3C, 1'b1);
    @(posedge Clk); #1;
    checks++; if ({OutValid, DataOut} !== {1'b1, 8'h30}) begin errors++; $display("FAIL bp_and got v %b d %h exp 1 30", OutValid, DataOut); end
    drive(S_ADD, 8'h01, 8'h01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      checks++; if ({OutValid, InReady, DataOut} !== {1'b1, 1'b0, 8'h30}) begin errors++; $display("FAIL bp_hold%0d got v %b r %b d %h exp 1 0 30", i, OutValid, InReady, DataOut); end
    end
    @(negedge Clk);
    OutReady = 1'b1; Sel = S_OR; DataA = 8'hF0; DataB = 8'h0F; InValid = 1'b1;
    #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", InReady); end
    @(posedge Clk); #1;
    checks++; if ({OutValid, DataOut} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL bp_or got v %b d %h exp 1 ff", OutValid, DataOut); end
    drive(S_AND, 8'h00, 8'h00, 1'b0);
    @(posedge Clk); #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", OutValid); end
  endtask

  task automatic test_multu();
    OutReady = 1'b1;
    drive(S_MUL, 8'h00, 8'h5A, 1'b1);
    @(posedge Clk);
    @(negedge Clk); InValid = 1'b0;
    repeat (8) @(posedge Clk);
    #1;
    checks++; if ({OutValid, Zero, DataOutHi, DataOut} !== {1'b1, 1'b1, 8'h00, 8'h00}) begin errors++; $display("FAIL mul_zero got v %b z %b %h%h exp 1 1 0000", OutValid, Zero, DataOutHi, DataOut); end
    drive(S_MUL, 8'hFF, 8'hFF, 1'b1);
    @(posedge Clk); #1;
    checks++; if ({InReady, OutValid} !== 2'b00) begin errors++; $display("FAIL mul_accept got r %b v %b exp 0 0", InReady, OutValid); end
    @(negedge Clk); InValid = 1'b0;
    for (int i = 1; i < 8; i++) begin
      @(posedge Clk); #1;
      checks++; if ({InReady, OutValid} !== 2'b00) begin errors++; $display("FAIL mul_busy%0d got r %b v %b exp 0 0", i, InReady, OutValid); end
    end
    @(posedge Clk); #1;
    checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL mul_valid got %b exp 1", OutValid); end
    checks++; if ({DataOutHi, DataOut} !== 16'hFE01) begin errors++; $display("FAIL mul_data got %h%h exp fe01", DataOutHi, DataOut); end
    checks++; if ({Zero, Cout, Overflow, Illegal, InReady} !== 5'b00001) begin errors++; $display("FAIL mul_flags zcoir got %b exp 00001", {Zero, Cout, Overflow, Illegal, InReady}); end
    @(posedge Clk); #1;
    checks++; if ({OutValid, DataOutHi} !== {1'b0, 8'hFE}) begin errors++; $display("FAIL mul_drain got v %b hi %h exp 0 fe", OutValid, DataOutHi); end
  endtask

  task automatic test_reset_mid_mul();
    int stale;
    OutReady = 1'b1;
    drive(S_MUL, 8'hFF, 8'hFF, 1'b1);
    @(posedge Clk);
    @(negedge Clk); InValid = 1'b0;
    repeat (3) @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    checks++; if ({OutValid, DataOutHi, DataOut} !== 17'h0) begin errors++; $display("FAIL rmul_clear got v %b %h%h exp 0 0000", OutValid, DataOutHi, DataOut); end
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL rmul_ready got %b exp 1", InReady); end
    stale = 0;
    repeat (12) begin
      @(posedge Clk); #1;
      if (OutValid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rmul_stale got %0d valid cycles exp 0", stale); end
  endtask

  task automatic test_shift();
    logic [7:0] expSll, expSrl;
    logic       expIll, expZero;
`ifdef ALU_SHIFT_EN
    expSll = 8'h08; expSrl = 8'h10; expIll = 1'b0; expZero = 1'b0;
`else
    expSll = 8'h00; expSrl = 8'h00; expIll = 1'b1; expZero = 1'b1;
`endif
    OutReady = 1'b1;
    drive(S_SLL, 8'h81, 8'h03, 1'b1);
    @(posedge Clk); #1;
    checks++; if ({OutValid, DataOut} !== {1'b1, expSll}) begin errors++; $display("FAIL sll_data got v %b d %h exp 1 %h", OutValid, DataOut, expSll); end
    checks++; if ({Illegal, Zero, Cout, Overflow, DataOutHi} !== {expIll, expZero, 2'b00, 8'h00}) begin errors++; $display("FAIL sll_flags got izco %b%b%b%b hi %h exp %b%b00 00", Illegal, Zero, Cout, Overflow, DataOutHi, expIll, expZero); end
    drive(S_SRL, 8'h81, 8'h03, 1'b1);
    @(posedge Clk); #1;
    checks++; if ({DataOut, Illegal, Zero} !== {expSrl, expIll, expZero}) begin errors++; $display("FAIL srl got d %h i %b z %b exp %h %b %b", DataOut, Illegal, Zero, expSrl, expIll, expZero); end
    drive(S_AND, 8'h00, 8'h00, 1'b0);
    @(posedge Clk); #1;
  endtask

  task automatic test_back_to_back();
    OutReady = 1'b1;
    drive(S_ADD, 8'hFF, 8'h01, 1'b1);
    @(posedge Clk); #1;
    checks++; if ({OutValid, DataOut, Zero, Cout, Overflow} !== {1'b1, 8'h00, 3'b110}) begin errors++; $display("FAIL b2b_add got v %b d %h zco %b%b%b exp 1 00 110", OutValid, DataOut, Zero, Cout, Overflow); end
    drive(S_SUB, 8'h80, 8'h01, 1'b1);
    @(posedge Clk); #1;
    checks++; if ({OutValid, DataOut, Zero, Cout, Overflow} !== {1'b1, 8'h7F, 3'b011}) begin errors++; $display("FAIL b2b_sub_ovf got v %b d %h zco %b%b%b exp 1 7f 011", OutValid, DataOut, Zero, Cout, Overflow); end
    drive(S_SUB, 8'h10, 8'h20, 1'b1);
    @(posedge Clk); #1;
    checks++; if ({OutValid, DataOut, Zero, Cout, Overflow} !== {1'b1, 8'hF0, 3'b000}) begin errors++; $display("FAIL b2b_sub_borrow got v %b d %h zco %b%b%b exp 1 f0 000", OutValid, DataOut, Zero, Cout, Overflow); end
    drive(S_OR, 8'hA0, 8'h05, 1'b1);
    @(posedge Clk); #1;
    checks++; if ({OutValid, DataOut, Cout, Overflow} !== {1'b1, 8'hA5, 2'b00}) begin errors++; $display("FAIL b2b_or got v %b d %h co %b%b exp 1 a5 00", OutValid, DataOut, Cout, Overflow); end
    drive(S_AND, 8'h00, 8'h00, 1'b0);
    @(posedge Clk); #1;
    checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", OutValid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_backpressure();
    test_multu();
    test_reset_mid_mul();
    test_shift();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised WIDTH-bit ALU for the pipelined datapath. Successor to the per-bit ALU slice.
- Registered result with valid/ready handshakes on both input and output.
- Adds ops the slice cannot do: SLT, a multi-cycle unsigned shift-add multiply, and flag outputs.
- Sits in the EX stage. The pipeline controller stalls on InReady.

Parameters:
- WIDTH, 32, operand/result width (>=4).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width.

Ports:
- Clk, input, 1, rising-edge clock.
- Reset_n, input, 1, asynchronous active-low reset.
- InValid, input, 1, operands/op valid.
- InReady, output, 1, unit can accept.
- Sel, input, 3, op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 MULTU, 100 SLL, 101 SRL.
- DataA, input, WIDTH, operand A.
- DataB, input, WIDTH, operand B (shift amount = DataB[CNT_W-2:0]).
- OutValid, output, 1, result valid.
- OutReady, input, 1, consumer accepts result.
- DataOut, output, WIDTH, result (MULTU low half).
- DataOutHi, output, WIDTH, MULTU high half; 0 for other ops.
- Zero, output, 1, DataOut==0 (MULTU: both halves 0).
- Cout, output, 1, carry-out of ADD/SUB (SUB: 1 = no borrow); 0 otherwise.
- Overflow, output, 1, signed overflow of ADD/SUB; 0 otherwise.
- Illegal, output, 1, op not supported in this build.

Behaviour:
- Reset (async, Reset_n=0): state=IDLE; OutValid=0; DataOut, DataOutHi, Zero, Cout, Overflow, Illegal = 0; counter=0. Reset mid-MULTU discards the operation and produces no output.
- States: IDLE, MUL.
- InReady = (state==IDLE) && (!OutValid || OutReady). Combinational.
- Accept = InValid && InReady, evaluated at the rising edge.
- Single-cycle ops (AND, OR, ADD, SUB, SLT, and shifts when enabled):
  - Result and flags registered on the accept edge.
  - OutValid=1 from that edge. Latency 1.
- SUB: A + ~B + 1.
- SLT: DataOut = {0..0, signed(A)<signed(B)}. SLT itself is computed without overflow error; the Cout/Overflow flags read 0 for SLT.
- MULTU:
  - Accept edge: latch A and B; clear the 2*WIDTH accumulator; counter=WIDTH; state->MUL.
  - Each MUL cycle: if B[0], add A to the upper half; shift {carry, acc} right by 1; shift B right; counter-1.
  - On the edge where counter goes 1->0: load DataOut/DataOutHi/Zero, OutValid=1, state->IDLE.
  - OutValid therefore rises WIDTH edges after the accept edge. InReady=0 throughout MUL.
- Output hold: while OutValid && !OutReady, all outputs are held stable.
  - OutValid && OutReady with no new accept: OutValid->0 at the edge. Data is don't-care but is held.
  - OutValid && OutReady && Accept in the same cycle (back-to-back single-cycle op): the new result replaces the old one and OutValid stays 1.
- InValid while InReady=0: ignored. The producer must hold its inputs.
- Arithmetic is modulo 2^WIDTH. Wrap-around is reported only through Cout/Overflow.
- Unsupported Sel: single-cycle, DataOut=0, DataOutHi=0, Zero=1, Illegal=1, other flags 0. Illegal=0 for every supported op.

Optional Feature:
- Macro ALU_SHIFT_EN.
- Defined:
  - Sel 100 = SLL, Sel 101 = SRL (logical) by DataB[CNT_W-2:0], single-cycle barrel shift.
  - Shift amount >= WIDTH yields 0.
- Undefined:
  - Sel 100/101 are unsupported and take the Illegal path.
  - No shifter logic is instantiated.

Test Plan:
- WIDTH=8, ADD A=0x7F B=0x01 -> DataOut=0x80, Overflow=1, Cout=0, Zero=0, OutValid high 1 edge after accept.
- SUB A=0x05 B=0x05 -> DataOut=0x00, Zero=1, Cout=1, Overflow=0. SLT A=0xFF B=0x01 -> DataOut=0x01.
- MULTU A=0xFF B=0xFF, OutReady=1 -> InReady=0 for 8 cycles; OutValid after 8th edge with DataOutHi=0xFE, DataOut=0x01, Zero=0.
- Back-pressure: AND result pending with OutReady=0 for 3 cycles -> DataOut stable, InReady=0, new InValid ignored. OutReady=1 with InValid (OR) -> OR result the next edge, OutValid stays 1.
- Reset_n pulsed low during cycle 4 of MULTU -> outputs zero immediately, state IDLE, InReady=1 after release, no stale OutValid.
- Sel=100, A=0x81, B=0x03 -> with ALU_SHIFT_EN DataOut=0x08, Illegal=0; without it DataOut=0x00, Zero=1, Illegal=1.
